// File: rtl/fifo_pkg.sv
// fifo_pkg: widths shared by fifo_sync and the read-side stream adapter.
package fifo_pkg;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order skid buffer; e0 is always the oldest entry.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] e0, e1;
    assign dout = e0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ <= '0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            if (pop && occ == 2'd2) e0 <= e1;
            else if (push && (pop || occ == 2'd0)) e0 <= din;
            if (push && (occ == 2'd2 ? pop : (occ == 2'd1 && !pop))) e1 <= din;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with registered read data, valid the cycle after read_en.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = write_en && !full;
    assign rd    = read_en && !empty;
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= write_data;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            read_data <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) begin
                rptr      <= rptr + 1'b1;
                read_data <= mem[rptr];
            end
            count <= count + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains fifo_sync into a valid/ready stream with packet framing.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] words_out
);
    logic [1:0]       occ;
    logic             inflight, pop;
    logic [CNT_W-1:0] beat;
    assign m_valid = occ != 2'd0;
    assign pop     = m_valid && m_ready;
    // m_ready feeds fifo_read_en combinationally: a pop frees a slot in the same cycle.
    assign fifo_read_en = !reset && enable && !fifo_empty &&
                          ({1'b0, occ} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    assign m_last = m_valid && beat == CNT_W'(PKT_LEN - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight  <= 1'b0;
            beat      <= '0;
            words_out <= '0;
        end else begin
            inflight <= fifo_read_en;
            if (pop) begin
                beat      <= beat == CNT_W'(PKT_LEN - 1) ? '0 : beat + 1'b1;
                words_out <= words_out + 1'b1;
            end
        end
    end
    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_data_out),
        .dout  (m_data),
        .occ   (occ)
    );
endmodule
